// File: rtl/episode_controller.sv
// -----------------------------------------------------------------------------
// episode_controller
// Sequencing FSM for Dyna-Q training. It runs agent steps and counts the steps
// in each episode. After every step it checks the terminal conditions through
// an external comparator: the goal (reward all ones) first, then the step limit.
// It ends episodes, pulses agent resets, counts episodes and flags completion
// of the training run.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         one-cycle request to begin a training run (IDLE/DONE only)
//   step_done     one-cycle pulse from the datapath: step finished
//   equal_signal  comparator result for the currently driven select
//   select        comparator mux: 0 = reward goal check, 1 = step-limit check
//   step_count    steps taken in the current episode (feeds the comparator)
//   step_enable   datapath may execute a step
//   agent_reset   one-cycle pulse: return the agent to its start state
//   episode_done  one-cycle pulse at the end of each episode
//   goal_reached  outcome of the last finished episode (1 = goal, 0 = limit)
//   episode_count finished episodes in this run
//   train_done    level: run complete
// -----------------------------------------------------------------------------
module episode_controller #(
  parameter int unsigned STEP_LENGTH    = 5,
  parameter int unsigned EPISODE_LENGTH = 10,
  parameter int unsigned MAX_EPISODES   = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      step_done,
  input  logic                      equal_signal,
  output logic                      select,
  output logic [STEP_LENGTH-1:0]    step_count,
  output logic                      step_enable,
  output logic                      agent_reset,
  output logic                      episode_done,
  output logic                      goal_reached,
  output logic [EPISODE_LENGTH-1:0] episode_count,
  output logic                      train_done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INIT      = 3'd1;
  localparam logic [2:0] STEP      = 3'd2;
  localparam logic [2:0] CHK_GOAL  = 3'd3;
  localparam logic [2:0] CHK_LIMIT = 3'd4;
  localparam logic [2:0] RESTART   = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam logic [STEP_LENGTH-1:0]    STEP_MAX     = '1;
  localparam logic [EPISODE_LENGTH-1:0] EPISODE_LAST = EPISODE_LENGTH'(MAX_EPISODES);

  logic [2:0]                state;
  logic [2:0]                state_next;
  logic [STEP_LENGTH-1:0]    step_count_next;
  logic [EPISODE_LENGTH-1:0] episode_count_next;
  logic [EPISODE_LENGTH-1:0] episode_inc;
  logic                      goal_reached_next;
  logic                      select_next;
  logic                      step_enable_next;
  logic                      agent_reset_next;
  logic                      episode_done_next;
  logic                      train_done_next;

  assign episode_inc = episode_count + EPISODE_LENGTH'(1);

  // State register plus registered outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      step_count    <= '0;
      episode_count <= '0;
      goal_reached  <= 1'b0;
      select        <= 1'b0;
      step_enable   <= 1'b0;
      agent_reset   <= 1'b0;
      episode_done  <= 1'b0;
      train_done    <= 1'b0;
    end else begin
      state         <= state_next;
      step_count    <= step_count_next;
      episode_count <= episode_count_next;
      goal_reached  <= goal_reached_next;
      select        <= select_next;
      step_enable   <= step_enable_next;
      agent_reset   <= agent_reset_next;
      episode_done  <= episode_done_next;
      train_done    <= train_done_next;
    end
  end

  // Next-state, counter updates, and Moore outputs decoded from the next state
  // so that the registered outputs line up with the state they belong to.
  always_comb begin
    state_next         = state;
    step_count_next    = step_count;
    episode_count_next = episode_count;
    goal_reached_next  = goal_reached;

    case (state)
      IDLE: begin
        if (start) state_next = INIT;
      end
      INIT: begin
        step_count_next    = '0;
        episode_count_next = '0;
        goal_reached_next  = 1'b0;
        state_next         = STEP;
      end
      STEP: begin
        if (step_done) begin
          // Saturate rather than wrap so a stuck comparator never rolls over.
          step_count_next = (step_count == STEP_MAX) ? step_count
                                                     : step_count + STEP_LENGTH'(1);
          state_next      = CHK_GOAL;
        end
      end
      CHK_GOAL: begin
        if (equal_signal) begin
          goal_reached_next = 1'b1;
          state_next        = RESTART;
        end else begin
          state_next = CHK_LIMIT;
        end
      end
      CHK_LIMIT: begin
        if (equal_signal) begin
          goal_reached_next = 1'b0;
          state_next        = RESTART;
        end else begin
          state_next = STEP;
        end
      end
      RESTART: begin
        step_count_next    = '0;
        episode_count_next = episode_inc;
        state_next         = (episode_inc == EPISODE_LAST) ? DONE : STEP;
      end
      DONE: begin
        if (start) state_next = INIT;
      end
      default: state_next = IDLE;
    endcase

    select_next       = (state_next == CHK_LIMIT);
    step_enable_next  = (state_next == STEP);
    agent_reset_next  = (state_next == INIT) || (state_next == RESTART);
    episode_done_next = (state_next == RESTART);
    train_done_next   = (state_next == DONE);
  end

endmodule

// File: tb/tb_episode_controller.sv
module tb_episode_controller;

  localparam int unsigned STEP_LENGTH    = 5;
  localparam int unsigned EPISODE_LENGTH = 10;
  localparam int unsigned MAX_EPISODES   = 3;
  localparam int unsigned STEP_LIMIT     = 25;
  localparam logic [9:0]  GOAL_REWARD    = 10'd1023;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic                      step_done;
  logic                      equal_signal;
  logic                      select;
  logic [STEP_LENGTH-1:0]    step_count;
  logic                      step_enable;
  logic                      agent_reset;
  logic                      episode_done;
  logic                      goal_reached;
  logic [EPISODE_LENGTH-1:0] episode_count;
  logic                      train_done;
  logic [9:0]                reward;

  int total  = 0;
  int passed = 0;

  // Reference model: plain counters of what the run should look like.
  int ref_steps;
  int ref_eps;
  int ref_goal;
  int ref_done;

  episode_controller #(
    .STEP_LENGTH   (STEP_LENGTH),
    .EPISODE_LENGTH(EPISODE_LENGTH),
    .MAX_EPISODES  (MAX_EPISODES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .step_done    (step_done),
    .equal_signal (equal_signal),
    .select       (select),
    .step_count   (step_count),
    .step_enable  (step_enable),
    .agent_reset  (agent_reset),
    .episode_done (episode_done),
    .goal_reached (goal_reached),
    .episode_count(episode_count),
    .train_done   (train_done)
  );

  // Behavioural is_equal_1023 comparator.
  assign equal_signal = select ? (int'(step_count) == STEP_LIMIT) : (reward == GOAL_REWARD);

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".select"},        32'(select),        0);
    check({tag, ".step_count"},    32'(step_count),    0);
    check({tag, ".step_enable"},   32'(step_enable),   0);
    check({tag, ".agent_reset"},   32'(agent_reset),   0);
    check({tag, ".episode_done"},  32'(episode_done),  0);
    check({tag, ".goal_reached"},  32'(goal_reached),  0);
    check({tag, ".episode_count"}, 32'(episode_count), 0);
    check({tag, ".train_done"},    32'(train_done),    0);
  endtask

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("init.agent_reset",  32'(agent_reset),  1);
    check("init.step_enable",  32'(step_enable),  0);
    check("init.episode_done", 32'(episode_done), 0);
    @(negedge clk);
    ref_steps = 0; ref_eps = 0; ref_goal = 0; ref_done = 0;
    check("run.step_enable",   32'(step_enable),   1);
    check("run.agent_reset",   32'(agent_reset),   0);
    check("run.step_count",    32'(step_count),    32'(ref_steps));
    check("run.episode_count", 32'(episode_count), 32'(ref_eps));
    check("run.goal_reached",  32'(goal_reached),  0);
    check("run.train_done",    32'(train_done),    0);
  endtask

  task automatic wait_step_enable(output bit ok);
    int n = 0;
    while (step_enable !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (step_enable === 1'b1);
    if (!ok) check("wait.step_enable_timeout", 32'(step_enable), 1);
  endtask

  // One agent step, checked at +1, +2, +3 (and +4 for a step-limit end) cycles.
  task automatic do_step(input logic [9:0] rew, input bit spurious, output bit terminal);
    bit ok;
    bit goal;
    bit limit;
    terminal = 1'b1;
    wait_step_enable(ok);
    if (!ok) return;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    reward    = rew;
    step_done = 1'b1;
    ref_steps = (ref_steps < 31) ? ref_steps + 1 : 31;
    goal      = (rew == GOAL_REWARD);
    limit     = (ref_steps == STEP_LIMIT);
    @(negedge clk);
    step_done = spurious;
    check("p1.step_enable", 32'(step_enable), 0);
    check("p1.select",      32'(select),      0);
    check("p1.step_count",  32'(step_count),  32'(ref_steps));
    @(negedge clk);
    step_done = 1'b0;
    if (goal) begin
      check("p2.goal.agent_reset",  32'(agent_reset),  1);
      check("p2.goal.episode_done", 32'(episode_done), 1);
      check("p2.goal.select",       32'(select),       0);
      ref_eps++; ref_goal = 1; ref_steps = 0;
      ref_done = (ref_eps == MAX_EPISODES);
      @(negedge clk);
      check("p3.goal.agent_reset",   32'(agent_reset),   0);
      check("p3.goal.step_count",    32'(step_count),    32'(ref_steps));
      check("p3.goal.goal_reached",  32'(goal_reached),  32'(ref_goal));
      check("p3.goal.episode_count", 32'(episode_count), 32'(ref_eps));
      check("p3.goal.train_done",    32'(train_done),    32'(ref_done));
      check("p3.goal.step_enable",   32'(step_enable),   32'(!ref_done));
    end else begin
      check("p2.select",       32'(select),       1);
      check("p2.agent_reset",  32'(agent_reset),  0);
      check("p2.step_count",   32'(step_count),   32'(ref_steps));
      @(negedge clk);
      check("p3.select", 32'(select), 0);
      if (limit) begin
        check("p3.limit.agent_reset",  32'(agent_reset),  1);
        check("p3.limit.episode_done", 32'(episode_done), 1);
        ref_eps++; ref_goal = 0; ref_steps = 0;
        ref_done = (ref_eps == MAX_EPISODES);
        @(negedge clk);
        check("p4.limit.episode_done",  32'(episode_done),  0);
        check("p4.limit.step_count",    32'(step_count),    32'(ref_steps));
        check("p4.limit.goal_reached",  32'(goal_reached),  32'(ref_goal));
        check("p4.limit.episode_count", 32'(episode_count), 32'(ref_eps));
        check("p4.limit.train_done",    32'(train_done),    32'(ref_done));
        check("p4.limit.step_enable",   32'(step_enable),   32'(!ref_done));
      end else begin
        check("p3.step_enable",  32'(step_enable),  1);
        check("p3.episode_done", 32'(episode_done), 0);
        terminal = 1'b0;
      end
    end
  endtask

  // Random non-goal rewards except on goal_step (0 or >25 means a timeout).
  task automatic run_episode(input int goal_step);
    bit term = 1'b0;
    int s = 1;
    while (!term && s <= 30) begin
      do_step((s == goal_step) ? GOAL_REWARD : 10'($urandom_range(0, 1022)), 1'b0, term);
      s++;
    end
  endtask

  task automatic check_done_hold();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step_done = 1'(i % 2);
    end
    step_done = 1'b0;
    @(negedge clk);
    check("done.train_done",    32'(train_done),    1);
    check("done.episode_count", 32'(episode_count), 32'(MAX_EPISODES));
    check("done.step_enable",   32'(step_enable),   0);
    check("done.goal_reached",  32'(goal_reached),  32'(ref_goal));
    check("done.model_done",    32'(train_done),    32'(ref_done));
  endtask

  initial begin
    bit term;
    bit ok;
    rst = 1'b1; start = 1'b0; step_done = 1'b0; reward = '0;
    repeat (2) @(negedge clk);
    start = 1'b1;                       // start together with reset: no effect
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check_all_zero("reset");

    // Idle with stray step_done pulses.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      step_done = 1'($urandom_range(0, 1));
    end
    step_done = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Run 1: goal at step 3, timeout, tie on step 25.
    start_run();
    run_episode(3);
    run_episode(0);
    run_episode(STEP_LIMIT);
    check_done_hold();

    // Run 2: restart from DONE, random goal episode, then reset mid-episode.
    start_run();
    run_episode(int'($urandom_range(1, 24)));
    for (int s = 1; s <= 11; s++) begin
      do_step(10'($urandom_range(0, 1022)), (s == 5), term);
    end
    wait_step_enable(ok);
    step_done = 1'b1;
    reward    = 10'($urandom_range(0, 1022));
    ref_steps++;
    @(negedge clk);
    step_done = 1'b1;                   // spurious during CHK_GOAL
    @(negedge clk);
    step_done = 1'b0;
    check("mid.select",     32'(select),     1);
    check("mid.step_count", 32'(step_count), 32'(ref_steps));
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    check("mid.no_episode_done", 32'(episode_done), 0);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    // Run 3: fully random episodes.
    start_run();
    for (int e = 0; e < int'(MAX_EPISODES); e++) begin
      run_episode(int'($urandom_range(1, 30)));
    end
    check_done_hold();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
